// File: rtl/clk_div_prog_if.sv
// Divisor programming bus for clk_div_prog: write strobe and value in,
// divisor in effect and reject pulse out.
interface clk_div_prog_if #(
    parameter int unsigned WIDTH = 28
);
    logic             div_wr;
    logic [WIDTH-1:0] div_val;
    logic [WIDTH-1:0] div_cur;
    logic             div_err;

    modport master (
        output div_wr,
        output div_val,
        input  div_cur,
        input  div_err
    );

    modport slave (
        input  div_wr,
        input  div_val,
        output div_cur,
        output div_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock/tick divider with divisor updates at the period boundary.
// Optional single-period step mode is enabled by defining CLK_DIV_STEP_EN.
module clk_div_prog #(
    parameter int unsigned      WIDTH       = 28,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50000000),
    parameter int unsigned      MIN_DIV     = 2
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    input  logic          step_req,
    clk_div_prog_if.slave cfg,
    output logic          clk_out,
    output logic          tick,
    output logic          busy
);

    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_cur_q;
    logic [WIDTH-1:0] pend_val;
    logic             pending;
    logic             div_err_q;
    logic             wr_ok;
    logic             wr_bad;
    logic             wrap;
    logic             run;

    assign wr_ok  = cfg.div_wr && (cfg.div_val >= MIN_DIV_W);
    assign wr_bad = cfg.div_wr && !wr_ok;
    // ">=" rather than "==" so a counter left above a shrunken divisor wraps at once
    assign wrap   = cnt >= (div_cur_q - WIDTH'(1));

    assign cfg.div_cur = div_cur_q;
    assign cfg.div_err = div_err_q;

`ifdef CLK_DIV_STEP_EN
    logic busy_q;
    assign run  = en | busy_q;
    assign busy = busy_q;
`else
    logic unused_step_req;
    assign run             = en;
    assign busy            = 1'b0;
    assign unused_step_req = step_req;
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            div_cur_q <= DEFAULT_DIV;
            pending   <= 1'b0;
            pend_val  <= '0;
            div_err_q <= 1'b0;
`ifdef CLK_DIV_STEP_EN
            busy_q    <= 1'b0;
`endif
        end else begin
            div_err_q <= wr_bad;
            tick      <= 1'b0;
            if (wr_ok) begin
                pend_val <= cfg.div_val;
                pending  <= 1'b1;
            end
            if (run) begin
                clk_out <= cnt < (div_cur_q >> 1);
                if (wrap) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    // a write landing on the wrap cycle bypasses the pending register
                    if (wr_ok) begin
                        div_cur_q <= cfg.div_val;
                        pending   <= 1'b0;
                    end else if (pending) begin
                        div_cur_q <= pend_val;
                        pending   <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
`ifdef CLK_DIV_STEP_EN
                busy_q <= busy_q & ~en & ~wrap;
`endif
            end else begin
                // frozen: only a pending divisor is applied, restarting the period
                if (pending) begin
                    div_cur_q <= pend_val;
                    cnt       <= '0;
                    if (!wr_ok) begin
                        pending <= 1'b0;
                    end
                end
`ifdef CLK_DIV_STEP_EN
                if (step_req) begin
                    busy_q <= 1'b1;
                    cnt    <= '0;
                end
`endif
            end
        end
    end

endmodule
